// File: rtl/cache_req_scheduler.sv
// cache_req_scheduler: arbitrates two trace requesters onto a single L1 cache
// command port, strobes each legal command once, waits a settle window, and
// reports hit/miss from the cache counter deltas as a tagged response.
module cache_req_scheduler #(
  parameter int unsigned SETTLE_CYCLES = 100,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned ADDR_W        = 32
) (
  input  logic              clk,
  input  logic              rstb,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_n,
  input  logic [ADDR_W-1:0] req0_addr,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_n,
  input  logic [ADDR_W-1:0] req1_addr,

  output logic              cache_valid,
  output logic [3:0]        cache_n,
  output logic [ADDR_W-1:0] cache_address,
  input  logic [CNT_W-1:0]  hit_cntr,
  input  logic [CNT_W-1:0]  miss_cntr,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic              rsp_hit,
  output logic              rsp_miss,
  output logic              rsp_err,

  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  // Settle window never exceeds 65535 cycles, so a 16-bit down-counter suffices.
  localparam int unsigned    WAIT_W    = 16;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SETTLE_CYCLES - 1);

  state_t              state;
  state_t              state_nx;

  logic                last_grant;
  logic                grant0;
  logic                grant1;
  logic                xfer;
  logic [3:0]          sel_n;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_legal;

  logic [3:0]          mode_q;
  logic [CNT_W-1:0]    hit_snap;
  logic [CNT_W-1:0]    miss_snap;
  logic [WAIT_W-1:0]   wait_cnt;

  // Modes the cache model understands; anything else is rejected unissued.
  function automatic logic mode_legal(input logic [3:0] n);
    case (n)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9: mode_legal = 1'b1;
      default:                                 mode_legal = 1'b0;
    endcase
  endfunction

  // Only plain read/write style modes move the counters meaningfully; mode 8
  // clears them, so a delta there would be a false report.
  function automatic logic mode_counted(input logic [3:0] n);
    mode_counted = (n <= 4'd2);
  endfunction

  // Round-robin arbitration: a lone requester wins, a tie goes to the one
  // that was not granted last.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || last_grant);
    grant1     = req1_valid && (!req0_valid || !last_grant);
    req0_ready = (state == S_IDLE) && grant0;
    req1_ready = (state == S_IDLE) && grant1;
    xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    sel_n      = grant1 ? req1_n    : req0_n;
    sel_addr   = grant1 ? req1_addr : req0_addr;
    sel_legal  = mode_legal(sel_n);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rstb) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_nx    = state;
    cache_valid = 1'b0;
    rsp_valid   = 1'b0;
    busy        = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (xfer) begin
          state_nx = sel_legal ? S_ISSUE : S_RESP;
        end
      end
      S_ISSUE: begin
        cache_valid = 1'b1;
        state_nx    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt == '0) begin
          state_nx = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Command latch, counter snapshot, settle countdown and response capture.
  always_ff @(posedge clk) begin
    if (rstb) begin
      last_grant    <= 1'b1;
      cache_n       <= '0;
      cache_address <= '0;
      mode_q        <= '0;
      hit_snap      <= '0;
      miss_snap     <= '0;
      wait_cnt      <= '0;
      rsp_id        <= 1'b0;
      rsp_hit       <= 1'b0;
      rsp_miss      <= 1'b0;
      rsp_err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (xfer) begin
            last_grant <= grant1;
            rsp_id     <= grant1;
            mode_q     <= sel_n;
            hit_snap   <= hit_cntr;
            miss_snap  <= miss_cntr;
            rsp_hit    <= 1'b0;
            rsp_miss   <= 1'b0;
            rsp_err    <= !sel_legal;
            // The cache port only ever shows commands that were strobed.
            if (sel_legal) begin
              cache_n       <= sel_n;
              cache_address <= sel_addr;
            end
          end
        end
        S_ISSUE: begin
          wait_cnt <= WAIT_LOAD;
        end
        S_WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else begin
            // Inequality compare so a counter wrapping to zero still counts.
            rsp_hit  <= mode_counted(mode_q) && (hit_cntr  != hit_snap);
            rsp_miss <= mode_counted(mode_q) && (miss_cntr != miss_snap);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_req_scheduler.sv
// Scoreboard bench for cache_req_scheduler: a behavioural cache model with
// planned counter effects, round-robin grant model and expected-response queue.
`timescale 1ns/1ps
module tb_cache_req_scheduler;

  localparam int unsigned S = 100;
  localparam int K_NONE  = 0;
  localparam int K_HIT   = 1;
  localparam int K_MISS  = 2;
  localparam int K_BOTH  = 3;
  localparam int K_CLEAR = 4;

  typedef struct { logic [3:0] n; logic [31:0] addr; int kind; int d; } cmd_t;
  typedef struct { int cyc; logic id; logic hit; logic miss; logic err; } rsp_t;
  typedef struct { int cyc; logic [3:0] n; logic [31:0] addr; int kind; int d; } stb_t;

  logic        clk = 1'b0;
  logic        rstb;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_n, req1_n;
  logic [31:0] req0_addr, req1_addr;
  logic        cache_valid;
  logic [3:0]  cache_n;
  logic [31:0] cache_address;
  logic [15:0] hit_cntr, miss_cntr;
  logic        rsp_valid, rsp_ready;
  logic        rsp_id, rsp_hit, rsp_miss, rsp_err;
  logic        busy;

  cache_req_scheduler #(
    .SETTLE_CYCLES(S),
    .CNT_W(16),
    .ADDR_W(32)
  ) dut (
    .clk(clk), .rstb(rstb),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_n(req0_n), .req0_addr(req0_addr),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_n(req1_n), .req1_addr(req1_addr),
    .cache_valid(cache_valid), .cache_n(cache_n), .cache_address(cache_address),
    .hit_cntr(hit_cntr), .miss_cntr(miss_cntr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_hit(rsp_hit), .rsp_miss(rsp_miss), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  cmd_t cmdq0[$];
  cmd_t cmdq1[$];
  cmd_t cur0, cur1;
  rsp_t exp_q[$];
  stb_t stb_q[$];
  logic xfer0 = 1'b0, xfer1 = 1'b0;
  logic last_grant_m = 1'b1;
  int   outstanding = 0;
  int   gap_max = 0;
  logic rdy_rand = 1'b0;
  int   hold = 0;
  logic rsp_seen = 1'b0;
  logic pend_active = 1'b0;
  int   pend_at = 0;
  int   pend_kind = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic legal(input logic [3:0] n);
    return (n <= 4'd4) || (n == 4'd8) || (n == 4'd9);
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    int r;
    logic [3:0] leg[7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9};
    logic [3:0] ill[9] = '{4'd5, 4'd6, 4'd7, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    if ($urandom_range(0, 4) == 0) c.n = ill[$urandom_range(0, 8)];
    else if ($urandom_range(0, 1) == 0) c.n = 4'($urandom_range(0, 2));
    else c.n = leg[$urandom_range(0, 6)];
    c.addr = $urandom();
    c.kind = (c.n == 4'd8) ? K_CLEAR : int'($urandom_range(0, 3));
    r = int'($urandom_range(0, 9));
    if (r == 0) c.d = int'(S);
    else if (r == 1) c.d = int'(S) + 1;
    else if (r == 2) c.d = 1;
    else c.d = int'($urandom_range(2, S - 1));
    return c;
  endfunction

  // Cycle count and cache model: planned counter effects land just after an edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (pend_active && cyc == pend_at) begin
        case (pend_kind)
          K_HIT:   hit_cntr  = hit_cntr + 16'd1;
          K_MISS:  miss_cntr = miss_cntr + 16'd1;
          K_BOTH:  begin hit_cntr = hit_cntr + 16'd1; miss_cntr = miss_cntr + 16'd1; end
          K_CLEAR: begin hit_cntr = '0; miss_cntr = '0; end
          default: begin end
        endcase
        pend_active = 1'b0;
      end
    end
  end

  // Requester drivers: hold a command until it is taken, then fetch the next.
  initial begin
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_n = '0; req1_n = '0; req0_addr = '0; req1_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (xfer0) begin req0_valid = 1'b0; xfer0 = 1'b0; end
      if (xfer1) begin req1_valid = 1'b0; xfer1 = 1'b0; end
      if (!req0_valid && cmdq0.size() > 0 && $urandom_range(0, gap_max) == 0) begin
        cur0 = cmdq0.pop_front();
        req0_valid = 1'b1; req0_n = cur0.n; req0_addr = cur0.addr;
      end
      if (!req1_valid && cmdq1.size() > 0 && $urandom_range(0, gap_max) == 0) begin
        cur1 = cmdq1.pop_front();
        req1_valid = 1'b1; req1_n = cur1.n; req1_addr = cur1.addr;
      end
    end
  end

  // Response consumer with occasional back-pressure bursts.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rdy_rand) rsp_ready = 1'b1;
      else if (hold > 0) begin rsp_ready = 1'b0; hold--; end
      else if ($urandom_range(0, 4) == 0) begin rsp_ready = 1'b0; hold = int'($urandom_range(0, 11)); end
      else rsp_ready = 1'b1;
    end
  end

  // Grant model and stimulus-side scoreboard push.
  cmd_t mc;
  rsp_t mr;
  logic mwin;
  logic [1:0] mexp;
  always @(negedge clk) begin
    if (!rstb) begin
      mwin = (req0_valid && req1_valid) ? !last_grant_m : req1_valid;
      mexp = (outstanding == 0 && (req0_valid || req1_valid)) ? (mwin ? 2'b10 : 2'b01) : 2'b00;
      chk("req_ready", 64'({req1_ready, req0_ready}), 64'(mexp));
      if (mexp != 2'b00) begin
        mc = mwin ? cur1 : cur0;
        if (mwin) xfer1 = 1'b1; else xfer0 = 1'b1;
        last_grant_m = mwin;
        outstanding++;
        mr.id   = mwin;
        mr.err  = !legal(mc.n);
        mr.hit  = (mc.n <= 4'd2) && mc.d <= int'(S) && (mc.kind == K_HIT  || mc.kind == K_BOTH);
        mr.miss = (mc.n <= 4'd2) && mc.d <= int'(S) && (mc.kind == K_MISS || mc.kind == K_BOTH);
        mr.cyc  = mr.err ? cyc + 1 : cyc + 2 + int'(S);
        exp_q.push_back(mr);
        if (!mr.err) stb_q.push_back('{cyc + 1, mc.n, mc.addr, mc.kind, mc.d});
      end
    end
  end

  // Cache-port monitor: every strobe must match the next expected issue.
  stb_t ms;
  always @(negedge clk) begin
    #1;
    if (!rstb) begin
      if (cache_valid) begin
        if (stb_q.size() == 0) chk("cache_valid_unexpected", 64'(cache_valid), 64'd0);
        else begin
          ms = stb_q.pop_front();
          chk("strobe_cycle", 64'(cyc), 64'(ms.cyc));
          chk("cache_n", 64'(cache_n), 64'(ms.n));
          chk("cache_address", 64'(cache_address), 64'(ms.addr));
          pend_active = 1'b1;
          pend_at     = ms.cyc + ms.d;
          pend_kind   = ms.kind;
        end
      end else if (stb_q.size() > 0 && stb_q[0].cyc < cyc) begin
        chk("cache_valid_missing", 64'(cache_valid), 64'd1);
        void'(stb_q.pop_front());
      end
    end
  end

  // Response monitor: compares against the scoreboard head while presented.
  rsp_t me;
  always @(negedge clk) begin
    #1;
    if (!rstb) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
        else begin
          me = exp_q[0];
          if (!rsp_seen) begin
            chk("rsp_latency", 64'(cyc), 64'(me.cyc));
            rsp_seen = 1'b1;
          end
          chk("rsp_fields", 64'({rsp_id, rsp_hit, rsp_miss, rsp_err}),
              64'({me.id, me.hit, me.miss, me.err}));
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            outstanding--;
            rsp_seen = 1'b0;
          end
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
        chk("rsp_missing", 64'(rsp_valid), 64'd1);
        void'(exp_q.pop_front());
        outstanding--;
        rsp_seen = 1'b0;
      end
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while ((cmdq0.size() + cmdq1.size() != 0 || req0_valid || req1_valid || outstanding != 0)
           && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 20000) chk(name, 64'(outstanding), 64'd0);
    repeat (3) @(posedge clk);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_cache_valid"}, 64'(cache_valid), 64'd0);
  endtask

  initial begin
    int n;
    rstb = 1'b1;
    rsp_ready = 1'b1;
    hit_cntr = 16'h0010;
    miss_cntr = 16'h0020;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset_cache_n", 64'(cache_n), 64'd0);
    chk("reset_cache_address", 64'(cache_address), 64'd0);
    chk("reset_rsp_fields", 64'({rsp_id, rsp_hit, rsp_miss, rsp_err}), 64'd0);
    @(posedge clk);
    #1 rstb = 1'b0;

    // Continuous contention straight after reset: requester 0 takes the first tie.
    gap_max = 0;
    for (int i = 0; i < 3; i++) begin
      cmdq0.push_back('{4'(i), 32'h1000_0000 + 32'(i), K_HIT, 5});
      cmdq1.push_back('{4'(i + 1), 32'h2000_0000 + 32'(i), K_MISS, 7});
    end
    wait_drain("drain_rr");

    // Single miss, counter bumped three cycles after the strobe.
    cmdq0.push_back('{4'd0, 32'h10019D94, K_MISS, 3});
    wait_drain("drain_miss");

    // Illegal mode is answered immediately without touching the cache.
    cmdq1.push_back('{4'd5, 32'h0, K_NONE, 1});
    wait_drain("drain_illegal");

    // Modes 9 and 8 are strobed but never classified; 8 clears the counters.
    hit_cntr = 16'h0003;
    cmdq0.push_back('{4'd9, 32'h0000_4000, K_HIT, 10});
    cmdq0.push_back('{4'd8, 32'h0000_4040, K_CLEAR, 4});
    wait_drain("drain_mode89");

    // Random traffic with back-pressure, counters parked near wrap.
    hit_cntr = 16'hFFFF;
    miss_cntr = 16'hFFFE;
    gap_max = 3;
    rdy_rand = 1'b1;
    for (int i = 0; i < 25; i++) begin
      cmdq0.push_back(rand_cmd());
      cmdq1.push_back(rand_cmd());
    end
    wait_drain("drain_random");
    rdy_rand = 1'b0;

    // Reset in the middle of the settle window drops the command silently.
    cmdq0.push_back('{4'd0, 32'h10019D94, K_MISS, 60});
    n = 0;
    while (outstanding == 0 && n < 1000) begin @(posedge clk); n++; end
    chk("reset_wait_accept", 64'(outstanding), 64'd1);
    repeat (49) @(posedge clk);
    #1 rstb = 1'b1;
    @(posedge clk);
    #1 rstb = 1'b0;
    exp_q.delete();
    stb_q.delete();
    outstanding = 0;
    pend_active = 1'b0;
    last_grant_m = 1'b1;
    rsp_seen = 1'b0;
    @(negedge clk);
    chk_idle_outputs("midreset");
    repeat (150) @(posedge clk);
    cmdq0.push_back('{4'd0, 32'h10019D94, K_MISS, 3});
    wait_drain("drain_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cache_req_scheduler.md
Name: cache_req_scheduler

Overview:
- Sequences the L1 cache model between two trace requesters (0 = data side, 1 = instruction side).
- Each requester supplies the cache's native command pair: 4-bit mode n and 32-bit address.
- Accepts one command at a time (round-robin), drives the cache valid/n/address interface, and waits a fixed settle window.
- Afterwards it classifies the access as hit or miss from the cache's hit_cntr/miss_cntr deltas and returns a tagged response.

Parameters:
- SETTLE_CYCLES, 100: cycles waited after the cache valid pulse before sampling the counters; legal range 1..65535.
- CNT_W, 16: width of the cache hit/miss counters.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rstb  in  1  reset, synchronous, active-high.
- req0_valid  in  1  requester 0 has a command.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_n  in  4  requester 0 mode.
- req0_addr  in  ADDR_W  requester 0 address.
- req1_valid, req1_ready, req1_n, req1_addr: same as requester 0, for requester 1.
- cache_valid  out  1  one-cycle command strobe to cache.
- cache_n  out  4  mode to cache.
- cache_address  out  ADDR_W  address to cache.
- hit_cntr  in  CNT_W  cache hit count.
- miss_cntr  in  CNT_W  cache miss count.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_id  out  1  requester that issued the command.
- rsp_hit  out  1  command produced a hit.
- rsp_miss  out  1  command produced a miss.
- rsp_err  out  1  illegal mode; command not issued.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rstb=1 at a posedge):
  - state=IDLE; cache_valid, cache_n, cache_address, rsp_* and busy all 0.
  - Round-robin pointer last_grant=1, so requester 0 wins the first tie.
  - Reset mid-operation drops the in-flight command with no response; the cache is not re-strobed.
- Legal modes: 0, 1, 2, 3, 4, 8, 9. Modes 5-7 and 10-15 are illegal.
- Handshake:
  - reqX_ready = (state==IDLE) && grantX. This is combinational, so at most one ready is high per cycle.
  - Transfer occurs when valid && ready. A requester holds n/addr stable while valid is high.
- Arbitration: if only one requester is valid, it is granted. If both are valid, the requester != last_grant is granted. last_grant updates on every transfer.
- States:
  - IDLE: on transfer, latch n/addr/id and snapshot hit_cntr/miss_cntr. Go to RESP with err=1 if n is illegal, else go to ISSUE.
  - ISSUE: cache_valid=1 for exactly this one cycle. cache_n and cache_address hold the latched values from ISSUE until the next transfer. Load wait counter = SETTLE_CYCLES-1. Go to WAIT.
  - WAIT: decrement each cycle. At count 0, go to RESP, computing:
    - rsp_hit = (hit_cntr != hit_snap), rsp_miss = (miss_cntr != miss_snap) for modes 0, 1, 2.
    - Both forced to 0 for modes 3, 4, 8, 9, because mode 8 clears the cache counters and would otherwise produce a false delta.
  - RESP: rsp_valid=1 with rsp_id/hit/miss/err held stable. On rsp_valid && rsp_ready, clear rsp_valid and go to IDLE.
- No request is accepted while in RESP, so there is no back-to-back accept in the same cycle as the response handshake.
- Latency:
  - Legal command: transfer edge E0, cache_valid during cycle E0+1, rsp_valid asserted from cycle E0+2+SETTLE_CYCLES.
  - Illegal command: rsp_valid from cycle E0+1, with cache_valid never asserted.
- Counter wrap: the deltas are an inequality compare, so wrap from 0xFFFF to 0 still reads as a change.
- A mode-8 command is legal: it is strobed to the cache and reported as hit=miss=0, err=0.

Test Plan:
- Scenario 1: req0 n=0, addr=0x10019D94; cache model increments miss_cntr 3 cycles after the strobe. Required: one cache_valid cycle with cache_n=0 and cache_address=0x10019D94; rsp_valid 102 cycles after accept with id=0, hit=0, miss=1, err=0.
- Scenario 2: after reset, req0 and req1 both valid continuously, rsp_ready=1. Required: grants in order 0, 1, 0, 1, and cache_n alternates with the requesters' n values.
- Scenario 3: req1 n=5, addr=0x0. Required: no cache_valid; rsp_valid on the next cycle with id=1, err=1, hit=0, miss=0.
- Scenario 4: req0 n=9, then n=8 with the cache clearing its counters (hit_cntr 0x0003 to 0). Required: both commands strobed; both responses hit=0, miss=0, err=0.
- Scenario 5: response pending with rsp_ready held low for 10 cycles and req1 valid. Required: rsp fields stable and req1_ready=0 throughout; req1 accepted the cycle after rsp_ready=1.
- Scenario 6: rstb=1 for one cycle during WAIT (cycle 50). Required: next cycle busy=0 and rsp_valid=0; no response for the dropped command; next request behaves as Scenario 1.
